// File: rtl/hyst_argmax.sv
// hyst_argmax: N-channel hysteresis winner tracker.
// A challenger replaces the current winner only after beating it by more
// than TH LSBs on DWELL consecutive valid samples (invalid cycles in between
// are ignored). Optional switch statistics counter: HYST_ARGMAX_STATS_EN.
module hyst_argmax #(
    parameter int N       = 4,
    parameter int WIDTH   = 8,
    parameter int TH      = 10,
    parameter int DWELL   = 3,
    parameter int RST_IDX = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [N*WIDTH-1:0]     ts_flat,
    output logic [$clog2(N)-1:0]   win_idx,
    output logic                   switch_pulse,
    output logic                   pending
`ifdef HYST_ARGMAX_STATS_EN
    ,
    output logic [15:0]            switch_cnt
`endif
);

    localparam int IW = $clog2(N);
    localparam logic [WIDTH:0]  TH_W    = (WIDTH+1)'(TH);
    localparam logic [7:0]      DWELL_W = 8'(DWELL);
    localparam logic [IW-1:0]   RST_W   = IW'(RST_IDX);

    typedef enum logic {HOLD, PEND} state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          win_d;
    logic [IW-1:0]          cand_q, cand_d;
    logic [7:0]             cnt_q, cnt_d, cnt_new;
    logic                   pulse_d;

    logic [WIDTH-1:0]       ts [N];
    logic [WIDTH:0]         thr;
    logic                   found;
    logic [IW-1:0]          best_idx;
    logic [WIDTH-1:0]       best_val;

    // Saturating increment for the 16-bit statistics counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign ts[g] = ts_flat[g*WIDTH +: WIDTH];
    end

    // Strongest qualifying challenger; the threshold sum is one bit wider so
    // a winner near full scale cannot be overtaken through wraparound.
    always_comb begin
        thr      = {1'b0, ts[win_idx]} + TH_W;
        found    = 1'b0;
        best_idx = '0;
        best_val = '0;
        for (int c = 0; c < N; c++) begin
            if (c != int'(win_idx) && {1'b0, ts[c]} > thr &&
                (!found || ts[c] > best_val)) begin
                found    = 1'b1;
                best_idx = IW'(c);
                best_val = ts[c];
            end
        end
    end

    // Next-state and dwell bookkeeping; every variable defaults to a hold.
    always_comb begin
        state_d = state_q;
        win_d   = win_idx;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        cnt_new = 8'd1;
        pulse_d = 1'b0;
        if (in_valid) begin
            if (!found) begin
                state_d = HOLD;
                cnt_d   = 8'd0;
            end else begin
                // Same candidate as last time extends the run, else restart.
                if (state_q == PEND && best_idx == cand_q)
                    cnt_new = cnt_q + 8'd1;
                cand_d = best_idx;
                if (cnt_new == DWELL_W) begin
                    win_d   = best_idx;
                    pulse_d = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = HOLD;
                end else begin
                    cnt_d   = cnt_new;
                    state_d = PEND;
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= HOLD;
        else     state_q <= state_d;
    end

    // Winner, candidate, dwell count and switch pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_idx      <= RST_W;
            cand_q       <= '0;
            cnt_q        <= 8'd0;
            switch_pulse <= 1'b0;
        end else begin
            win_idx      <= win_d;
            cand_q       <= cand_d;
            cnt_q        <= cnt_d;
            switch_pulse <= pulse_d;
        end
    end

    assign pending = (state_q == PEND);

`ifdef HYST_ARGMAX_STATS_EN
    // Count winner changes, saturating at full scale.
    always_ff @(posedge clk) begin
        if (rst)          switch_cnt <= 16'd0;
        else if (pulse_d) switch_cnt <= sat_inc16(switch_cnt);
    end
`else
    // Statistics counter not built; sat_inc16 is left unused.
`endif

endmodule
